// File: rtl/uart_rx_deserializer.sv
// Serial 8N1 receiver: start detect, mid-bit sampling, LSB-first reassembly,
// and a ready/read handshake toward the host.
module uart_rx_deserializer #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          div_msb_lsb,
  input  logic                 enable_rcv,
  input  logic                 ser_in,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] dout,
  output logic                 data_ready,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 enable_rcv_clk
);

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sin_s;
  logic                   fall;

  logic [15:0]          d;
  logic [15:0]          h;
  logic [15:0]          cnt, cnt_nx;
  logic [IW-1:0]        bit_idx, bit_idx_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 bit_end;
  logic                 load;

  assign d = (div_msb_lsb < 16'd2) ? 16'd2 : div_msb_lsb;
  assign h = d >> 1;

  // The last sync stage is the edge register: a start bit is seen the
  // cycle it is about to enter sin_s, which keeps div=2 sampling mid-bit.
  assign sin_s = sync[SYNC_STAGES-1];
  assign fall  = sin_s & ~sync[SYNC_STAGES-2];

  assign bit_end        = (cnt == d - 16'd1);
  assign enable_rcv_clk = (state != IDLE);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    load       = 1'b0;
    if (!enable_rcv) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fall) begin
            state_nx = START;
            cnt_nx   = '0;
          end
        end
        START: begin
          if (cnt == h) begin
            cnt_nx = '0;
            if (!sin_s) begin
              state_nx   = DATA;
              bit_idx_nx = '0;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_nx   = {sin_s, shift[DATA_BITS-1:1]};
            cnt_nx     = '0;
            bit_idx_nx = bit_idx + IW'(1);
            if (bit_idx == LAST) state_nx = STOP;
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            load     = 1'b1;
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sync    <= '1;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nx;
      sync    <= {sync[SYNC_STAGES-2:0], ser_in};
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
    end
  end

  // A load in the same cycle as a read keeps the new byte pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout        <= '0;
      data_ready  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (load) begin
        dout        <= shift;
        data_ready  <= 1'b1;
        framing_err <= ~sin_s;
      end else if (rd_en) begin
        data_ready <= 1'b0;
      end
      if (load && data_ready && !rd_en) begin
        overrun_err <= 1'b1;
      end else if (rd_en && data_ready) begin
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed scenarios plus
// randomized frames against a frame-level reference model.
module tb_uart_rx_deserializer;

  localparam int DB = 8;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic        enable_rcv;
  logic        ser_in;
  logic        rd_en;
  logic [7:0]  dout;
  logic        data_ready;
  logic        framing_err;
  logic        overrun_err;
  logic        enable_rcv_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int rise_cnt = 0;
  logic dr_q = 1'b0;

  uart_rx_deserializer #(
    .DATA_BITS  (DB),
    .SYNC_STAGES(SS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .div_msb_lsb   (div),
    .enable_rcv    (enable_rcv),
    .ser_in        (ser_in),
    .rd_en         (rd_en),
    .dout          (dout),
    .data_ready    (data_ready),
    .framing_err   (framing_err),
    .overrun_err   (overrun_err),
    .enable_rcv_clk(enable_rcv_clk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_ready && !dr_q) begin
      rise_cyc <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    dr_q <= data_ready;
  end

  function automatic int eff_div(input int dv);
    return (dv < 2) ? 2 : dv;
  endfunction

  // Cycles from the first clock edge that sees the start bit to the
  // edge that raises data_ready.
  function automatic int exp_lat(input int dv);
    int dd;
    dd = eff_div(dv);
    return SS + dd / 2 + 1 + (DB + 1) * dd;
  endfunction

  // Must be called at a negedge; leaves the line idle at a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int dv);
    int dd;
    dd = eff_div(dv);
    ser_in   = 1'b0;
    fall_cyc = cyc;
    repeat (dd) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      ser_in = b[i];
      repeat (dd) @(negedge clk);
    end
    ser_in = stop;
    repeat (dd) @(negedge clk);
    ser_in = 1'b1;
  endtask

  task automatic read_byte();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_rd_at(input int edge_no);
    while (cyc < edge_no - 1) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    enable_rcv = 1'b0;
    ser_in     = 1'b1;
    rd_en      = 1'b0;
    div        = 16'd16;
    repeat (3) @(negedge clk);
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout got=%h exp=00", dout);
    end
    checks++;
    if (data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=0", data_ready);
    end
    checks++;
    if (framing_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ferr got=%b exp=0", framing_err);
    end
    checks++;
    if (overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovr got=%b exp=0", overrun_err);
    end
    checks++;
    if (enable_rcv_clk !== 1'b0) begin
      errors++;
      $display("FAIL reset_rclk got=%b exp=0", enable_rcv_clk);
    end
    rst        = 1'b0;
    enable_rcv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    div = 16'd16;
    send_frame(8'hA5, 1'b1, 16);
    repeat (SS + 3) @(negedge clk);
    checks++;
    if (dout !== 8'hA5) begin
      errors++;
      $display("FAIL basic_dout got=%h exp=a5", dout);
    end
    checks++;
    if (data_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready got=%b exp=1", data_ready);
    end
    checks++;
    if (framing_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_ferr got=%b exp=0", framing_err);
    end
    checks++;
    if (rise_cyc - fall_cyc !== exp_lat(16)) begin
      errors++;
      $display("FAIL basic_latency got=%0d exp=%0d",
               rise_cyc - fall_cyc, exp_lat(16));
    end
    read_byte();
    checks++;
    if (data_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_read got=%b exp=0", data_ready);
    end
  endtask

  task automatic test_glitch();
    int  rc0;
    logic seen;
    rc0    = rise_cnt;
    seen   = 1'b0;
    ser_in = 1'b0;
    repeat (3) @(negedge clk);
    ser_in = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (enable_rcv_clk) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL glitch_rclk_pulse got=%b exp=1", seen);
    end
    checks++;
    if (enable_rcv_clk !== 1'b0) begin
      errors++;
      $display("FAIL glitch_rclk_end got=%b exp=0", enable_rcv_clk);
    end
    checks++;
    if (data_ready !== 1'b0 || rise_cnt !== rc0) begin
      errors++;
      $display("FAIL glitch_ready got=%b/%0d exp=0/%0d",
               data_ready, rise_cnt, rc0);
    end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 16);
    repeat (SS + 3) @(negedge clk);
    checks++;
    if (dout !== 8'h3C || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL ferr_byte got=%h/%b exp=3c/1", dout, data_ready);
    end
    checks++;
    if (framing_err !== 1'b1) begin
      errors++;
      $display("FAIL ferr_flag got=%b exp=1", framing_err);
    end
    read_byte();
    checks++;
    if (framing_err !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL ferr_hold got=%b/%b exp=1/0", framing_err, data_ready);
    end
    send_frame(8'h00, 1'b1, 16);
    repeat (SS + 3) @(negedge clk);
    checks++;
    if (framing_err !== 1'b0 || dout !== 8'h00 || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL ferr_clear got=%b/%h/%b exp=0/00/1",
               framing_err, dout, data_ready);
    end
    read_byte();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 16);
    repeat (SS + 3) @(negedge clk);
    checks++;
    if (dout !== 8'h22 || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_byte got=%h/%b exp=22/1", dout, data_ready);
    end
    checks++;
    if (overrun_err !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overrun got=%b exp=1", overrun_err);
    end
    read_byte();
    checks++;
    if (data_ready !== 1'b0 || overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_read got=%b/%b exp=0/0", data_ready, overrun_err);
    end
  endtask

  task automatic test_abort();
    int rc0;
    rc0    = rise_cnt;
    ser_in = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ser_in = ~ser_in;
      repeat (16) @(negedge clk);
    end
    enable_rcv = 1'b0;
    ser_in     = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (enable_rcv_clk !== 1'b0) begin
      errors++;
      $display("FAIL abort_rclk got=%b exp=0", enable_rcv_clk);
    end
    repeat (20) @(negedge clk);
    enable_rcv = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h7E, 1'b1, 16);
    repeat (SS + 3) @(negedge clk);
    checks++;
    if (rise_cnt !== rc0 + 1) begin
      errors++;
      $display("FAIL abort_count got=%0d exp=%0d", rise_cnt, rc0 + 1);
    end
    checks++;
    if (dout !== 8'h7E || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_byte got=%h/%b exp=7e/1", dout, data_ready);
    end
  endtask

  task automatic test_reset_midframe();
    ser_in = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (enable_rcv_clk !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy got=%b exp=1", enable_rcv_clk);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dout, data_ready, framing_err, overrun_err, enable_rcv_clk}
        !== 12'h000) begin
      errors++;
      $display("FAIL midrst_outputs got=%h/%b%b%b%b exp=00/0000", dout,
               data_ready, framing_err, overrun_err, enable_rcv_clk);
    end
    @(negedge clk);
    ser_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_div_clamp();
    int ld;
    div = 16'd1;
    send_frame(8'h81, 1'b1, 1);
    repeat (SS + 3) @(negedge clk);
    checks++;
    if (dout !== 8'h81 || data_ready !== 1'b1 || overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL div1_byte got=%h/%b/%b exp=81/1/0",
               dout, data_ready, overrun_err);
    end
    checks++;
    if (rise_cyc - fall_cyc !== exp_lat(1)) begin
      errors++;
      $display("FAIL div1_latency got=%0d exp=%0d",
               rise_cyc - fall_cyc, exp_lat(1));
    end
    div = 16'd3;
    @(negedge clk);
    ld = cyc + exp_lat(3);
    fork
      send_frame(8'h81, 1'b1, 3);
      pulse_rd_at(ld);
    join
    repeat (2) @(negedge clk);
    checks++;
    if (dout !== 8'h81 || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL div3_rd_load got=%h/%b exp=81/1", dout, data_ready);
    end
    checks++;
    if (overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL div3_no_overrun got=%b exp=0", overrun_err);
    end
    read_byte();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       st;
    int         dv;
    logic [7:0] m_dout;
    logic       m_dr;
    logic       m_ov;
    logic       m_fe;
    m_dr = 1'b0;
    m_ov = 1'b0;
    for (int n = 0; n < 14; n++) begin
      dv  = $urandom_range(0, 24);
      b   = 8'($urandom);
      st  = ($urandom_range(0, 3) != 0);
      div = 16'(dv);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      send_frame(b, st, dv);
      repeat (SS + 3) @(negedge clk);
      m_ov   = m_dr ? 1'b1 : m_ov;
      m_dr   = 1'b1;
      m_dout = b;
      m_fe   = ~st;
      checks++;
      if (dout !== m_dout || data_ready !== m_dr) begin
        errors++;
        $display("FAIL rand_byte n=%0d div=%0d got=%h/%b exp=%h/%b",
                 n, dv, dout, data_ready, m_dout, m_dr);
      end
      checks++;
      if (framing_err !== m_fe || overrun_err !== m_ov) begin
        errors++;
        $display("FAIL rand_flags n=%0d got=%b/%b exp=%b/%b",
                 n, framing_err, overrun_err, m_fe, m_ov);
      end
      if ($urandom_range(0, 1) == 1) begin
        read_byte();
        m_dr = 1'b0;
        m_ov = 1'b0;
        checks++;
        if (data_ready !== m_dr || overrun_err !== m_ov) begin
          errors++;
          $display("FAIL rand_read n=%0d got=%b/%b exp=0/0",
                   n, data_ready, overrun_err);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_div_clamp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
